// File: rtl/bcd_counter_3dig.sv
// ---------------------------------------------------------------------------
// bcd_counter_3dig
//
// Three-digit BCD up/down counter (000-999) driven by three raw push-buttons.
// Each button runs through a two-flop synchroniser, a counter-based debouncer
// and a rising-edge detector, producing a single-cycle press event. The
// events then step a registered three-digit BCD count that feeds the
// seven-segment display multiplexer downstream.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a new button
//                    level (default 500000 = 10 ms at 50 MHz; legal 2..2^24-1)
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET     in   asynchronous, active-high reset
//   BTN_UP    in   raw button, active-high, asynchronous to CLK
//   BTN_DOWN  in   raw button, active-high, asynchronous to CLK
//   BTN_CLR   in   raw button, active-high, asynchronous to CLK
//   units     out  BCD units digit, registered
//   tens      out  BCD tens digit, registered
//   hundreds  out  BCD hundreds digit, registered
//   WRAP      out  one-cycle pulse on 999->000 or 000->999, registered
//
// Build option
//   BCD_COUNTER_SATURATE_EN  when defined, UP at 999 and DOWN at 000 are
//                            ignored and WRAP stays 0. Undefined (default)
//                            gives modulo-1000 counting with the WRAP pulse.
//
// Event priority each cycle: CLR, then UP+DOWN together (no change), then
// UP, then DOWN.
// ---------------------------------------------------------------------------
module bcd_counter_3dig #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_CLR,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       WRAP
);

    localparam int NUM_BTNS = 3;
    localparam int UP_IDX   = 0;
    localparam int DOWN_IDX = 1;
    localparam int CLR_IDX  = 2;

    // Count value at which the accepted level flips on the next mismatching
    // sample.
    localparam logic [23:0] TERM_COUNT = 24'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press_evt;

    assign btn_raw = {BTN_CLR, BTN_DOWN, BTN_UP};

    // -----------------------------------------------------------------------
    // Per-button input path: synchroniser -> debouncer -> edge detector
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            logic        sync1_reg;
            logic        sync2_reg;
            logic        stable_reg;
            logic        stable_next;
            logic        stable_d_reg;
            logic [23:0] cnt_reg;
            logic [23:0] cnt_next;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= btn_raw[gi];
                    sync2_reg    <= sync1_reg;
                    stable_reg   <= stable_next;
                    stable_d_reg <= stable_reg;
                    cnt_reg      <= cnt_next;
                end
            end

            // The debouncer judges the level that sync2 is capturing on this
            // edge, so the run of mismatching samples starts counting on the
            // same edge that sync2 updates. This puts the flip of 'stable'
            // exactly DEBOUNCE_CYCLES edges after sync1 first sampled the new
            // level, and a level must persist for DEBOUNCE_CYCLES samples to
            // be accepted. The commit additionally requires sync2 to disagree
            // with 'stable', i.e. the level has settled through both stages.
            always_comb begin
                cnt_next    = cnt_reg;
                stable_next = stable_reg;
                if (sync1_reg == stable_reg) begin
                    cnt_next = '0;
                end else if ((cnt_reg == TERM_COUNT) && (sync2_reg != stable_reg)) begin
                    stable_next = ~stable_reg;
                    cnt_next    = '0;
                end else if (cnt_reg != TERM_COUNT) begin
                    cnt_next = cnt_reg + 24'd1;
                end
            end

            // Press event: accepted level just went high. Release is ignored.
            assign press_evt[gi] = stable_reg & ~stable_d_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // BCD count datapath. Digit 0 = units, 1 = tens, 2 = hundreds.
    // -----------------------------------------------------------------------
    logic [2:0][3:0] dig_reg;
    logic [2:0][3:0] dig_next;
    logic [2:0][3:0] inc_dig;
    logic [2:0][3:0] dec_dig;
    logic            inc_carry;
    logic            dec_borrow;
    logic            wrap_reg;
    logic            wrap_next;

    logic            evt_up;
    logic            evt_down;
    logic            evt_clr;

    assign evt_up   = press_evt[UP_IDX];
    assign evt_down = press_evt[DOWN_IDX];
    assign evt_clr  = press_evt[CLR_IDX];

    // Ripple increment across all three digits in one cycle. A carry out of
    // the hundreds digit means the count was 999. Digits above 9 cannot be
    // produced, but are mapped onto the 9 -> 0 path so the result stays BCD.
    always_comb begin
        inc_dig   = dig_reg;
        inc_carry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (inc_carry) begin
                if (dig_reg[i] >= 4'd9) begin
                    inc_dig[i] = 4'd0;
                end else begin
                    inc_dig[i] = dig_reg[i] + 4'd1;
                    inc_carry  = 1'b0;
                end
            end
        end
    end

    // Ripple decrement; a borrow out of the hundreds digit means the count
    // was 000. A non-BCD digit is pulled back to 9 without further borrow.
    always_comb begin
        dec_dig    = dig_reg;
        dec_borrow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (dec_borrow) begin
                if (dig_reg[i] == 4'd0) begin
                    dec_dig[i] = 4'd9;
                end else if (dig_reg[i] > 4'd9) begin
                    dec_dig[i] = 4'd9;
                    dec_borrow = 1'b0;
                end else begin
                    dec_dig[i] = dig_reg[i] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        dig_next  = dig_reg;
        wrap_next = 1'b0;
        if (evt_clr) begin
            dig_next = '0;
        end else if (evt_up && evt_down) begin
            dig_next = dig_reg;
        end else if (evt_up) begin
`ifdef BCD_COUNTER_SATURATE_EN
            if (!inc_carry) begin
                dig_next = inc_dig;
            end
`else
            dig_next  = inc_dig;
            wrap_next = inc_carry;
`endif
        end else if (evt_down) begin
`ifdef BCD_COUNTER_SATURATE_EN
            if (!dec_borrow) begin
                dig_next = dec_dig;
            end
`else
            dig_next  = dec_dig;
            wrap_next = dec_borrow;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dig_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            dig_reg  <= dig_next;
            wrap_reg <= wrap_next;
        end
    end

    assign units    = dig_reg[0];
    assign tens     = dig_reg[1];
    assign hundreds = dig_reg[2];
    assign WRAP     = wrap_reg;

endmodule

// File: tb/tb_bcd_counter_3dig.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_3dig
//
// Self-checking bench for bcd_counter_3dig with DEBOUNCE_CYCLES = 4 and a
// 20 ns clock. An integer reference model (accepted button levels tracked as
// run lengths of sampled raw levels, count kept as a plain 0..999 integer)
// is compared against the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations. Define BCD_COUNTER_SATURATE_EN for both
// bench and RTL to check the saturating build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_counter_3dig;

    localparam int D = 4;
`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic       BTN_CLR;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       WRAP;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_check_en = 1'b0;

    bcd_counter_3dig #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .BTN_UP  (BTN_UP),
        .BTN_DOWN(BTN_DOWN),
        .BTN_CLR (BTN_CLR),
        .units   (units),
        .tens    (tens),
        .hundreds(hundreds),
        .WRAP    (WRAP)
    );

    always #10 CLK = ~CLK;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int       m_cnt;
    bit       m_wrap;
    bit [2:0] m_samp;   // raw levels sampled at the previous edge {clr,down,up}
    bit [2:0] m_acc;    // accepted (debounced) level per button
    bit [2:0] m_evt;    // press accepted at the previous edge
    int       m_run[3]; // trailing samples disagreeing with the accepted level

    function automatic int run_len(bit samp, bit acc, int run);
        return (samp != acc) ? run + 1 : 0;
    endfunction

    function automatic int next_count(int c, bit [2:0] ev);
        if (ev[2]) return 0;
        if (ev[0] && ev[1]) return c;
        if (ev[0]) return (c == 999) ? (SAT ? 999 : 0) : c + 1;
        if (ev[1]) return (c == 0) ? (SAT ? 0 : 999) : c - 1;
        return c;
    endfunction

    function automatic bit next_wrap(int c, bit [2:0] ev);
        if (SAT || ev[2] || (ev[0] && ev[1])) return 1'b0;
        return (ev[0] && c == 999) || (ev[1] && c == 0);
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_cnt  <= 0;
            m_wrap <= 1'b0;
            m_samp <= '0;
            m_acc  <= '0;
            m_evt  <= '0;
            for (int b = 0; b < 3; b++) m_run[b] <= 0;
        end else begin
            m_cnt  <= next_count(m_cnt, m_evt);
            m_wrap <= next_wrap(m_cnt, m_evt);
            for (int b = 0; b < 3; b++) begin
                if (run_len(m_samp[b], m_acc[b], m_run[b]) == D) begin
                    m_acc[b] <= ~m_acc[b];
                    m_evt[b] <= ~m_acc[b];
                    m_run[b] <= 0;
                end else begin
                    m_run[b] <= run_len(m_samp[b], m_acc[b], m_run[b]);
                    m_evt[b] <= 1'b0;
                end
            end
            m_samp <= {BTN_CLR, BTN_DOWN, BTN_UP};
        end
    end

    // -----------------------------------------------------------------------
    // Checking helpers
    // -----------------------------------------------------------------------
    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int dut_val();
        return int'(hundreds) * 100 + int'(tens) * 10 + int'(units);
    endfunction

    always @(negedge CLK) begin
        if (model_check_en && !RESET) begin
            check("model_units",    int'(units),    m_cnt % 10);
            check("model_tens",     int'(tens),     (m_cnt / 10) % 10);
            check("model_hundreds", int'(hundreds), m_cnt / 100);
            check("model_wrap",     int'(WRAP),     int'(m_wrap));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change on falling edges)
    // -----------------------------------------------------------------------
    task automatic set_btns(input bit [2:0] lvl);
        {BTN_CLR, BTN_DOWN, BTN_UP} = lvl;
    endtask

    // Clean press of the buttons in mask; reports how many cycles WRAP was
    // high while the press was being processed.
    task automatic press(input bit [2:0] mask, output int wraps);
        wraps = 0;
        @(negedge CLK);
        set_btns(mask);
        repeat (D + 2) begin
            @(negedge CLK);
            if (WRAP) wraps++;
        end
        set_btns(3'b000);
        repeat (D + 3) begin
            @(negedge CLK);
            if (WRAP) wraps++;
        end
        $display("[TB] press %b -> %03d wrap_cycles=%0d", mask, dut_val(), wraps);
    endtask

    task automatic goto_count(input int target);
        int w;
        press(3'b100, w);
        if (SAT || target <= 500) begin
            for (int i = 0; i < target; i++) press(3'b001, w);
        end else begin
            for (int i = 0; i < 1000 - target; i++) press(3'b010, w);
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic random_phase(input int cycles);
        int       dur[3];
        bit [2:0] lvl;
        lvl = '0;
        for (int b = 0; b < 3; b++) dur[b] = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge CLK);
            for (int b = 0; b < 3; b++) begin
                if (dur[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    if (b == 2 && !lvl[b]) dur[b] = int'($urandom_range(20, 120));
                    else                   dur[b] = int'($urandom_range(1, 2 * D + 2));
                end else begin
                    dur[b]--;
                end
            end
            set_btns(lvl);
        end
        set_btns(3'b000);
        repeat (3 * D) @(negedge CLK);
        $display("[TB] random phase %0d cycles -> %03d", cycles, dut_val());
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        int w;
        RESET = 1'b1;
        set_btns(3'b000);
        repeat (3) @(negedge CLK);
        check("reset_value", dut_val(), 0);
        check("reset_wrap",  int'(WRAP), 0);
        RESET = 1'b0;
        model_check_en = 1'b1;

        // Single UP press held 20 cycles: 001 exactly at N+D+1, then steady.
        @(negedge CLK);
        BTN_UP = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            check("up_latency", dut_val(), (k >= D + 2) ? 1 : 0);
        end
        BTN_UP = 1'b0;
        repeat (12) @(negedge CLK);
        check("up_release", dut_val(), 1);
        check("model_pin_one", m_cnt, 1);
        $display("[TB] single up press -> %03d", dut_val());

        // Bounce: 2 high, 1 low, 2 high, low -> nothing accepted.
        pulse_reset();
        @(negedge CLK); BTN_UP = 1'b1;
        repeat (2) @(negedge CLK); BTN_UP = 1'b0;
        @(negedge CLK); BTN_UP = 1'b1;
        repeat (2) @(negedge CLK); BTN_UP = 1'b0;
        repeat (15) @(negedge CLK);
        check("bounce", dut_val(), 0);
        $display("[TB] bounce -> %03d", dut_val());

        // Carry across all digits.
        goto_count(99);
        check("preload_099", dut_val(), 99);
        press(3'b001, w);
        check("carry_100", dut_val(), 100);
        check("model_pin_100", m_cnt, 100);

        // UP at 999.
        goto_count(999);
        check("preload_999", dut_val(), 999);
        press(3'b001, w);
        check("up_at_999", dut_val(), SAT ? 999 : 0);
        check("up_at_999_wrap_cycles", w, SAT ? 0 : 1);

        // DOWN at 000.
        press(3'b100, w);
        check("clr_before_down", dut_val(), 0);
        press(3'b010, w);
        check("down_at_000", dut_val(), SAT ? 0 : 999);
        check("down_at_000_wrap_cycles", w, SAT ? 0 : 1);

        // Simultaneous events.
        goto_count(250);
        check("preload_250", dut_val(), 250);
        press(3'b011, w);
        check("up_down_together", dut_val(), 250);
        press(3'b101, w);
        check("clr_with_up", dut_val(), 0);

        // Asynchronous reset mid-count, checked before the next rising edge.
        goto_count(437);
        check("preload_437", dut_val(), 437);
        @(negedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("async_reset_value", dut_val(), 0);
        check("async_reset_wrap", int'(WRAP), 0);
        $display("[TB] async reset at 437 -> %03d", dut_val());
        @(negedge CLK);
        RESET = 1'b0;

        // DOWN held through reset: treated as a fresh press after release.
        goto_count(500);
        check("preload_500", dut_val(), 500);
        @(negedge CLK);
        BTN_DOWN = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("held_reset_value", dut_val(), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        for (int k = 1; k <= D + 3; k++) begin
            @(negedge CLK);
            check("held_after_reset", dut_val(), (k >= D + 2 && !SAT) ? 999 : 0);
            check("held_after_reset_wrap", int'(WRAP), (k == D + 2 && !SAT) ? 1 : 0);
        end
        BTN_DOWN = 1'b0;
        repeat (D + 3) @(negedge CLK);
        $display("[TB] down held through reset -> %03d", dut_val());

        // Randomised buttons with bounce, checked by the model every cycle.
        random_phase(4000);
        pulse_reset();
        random_phase(3000);

        model_check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_3dig.md
# bcd_counter_3dig

Three-digit BCD up/down counter (000–999) driven by three raw push-button inputs. Each button passes through a synchroniser and debouncer, then an edge detector. The block sits directly upstream of the 3-digit seven-segment display multiplexer and feeds its `units`/`tens`/`hundreds` inputs. All digit outputs are registered and are always valid BCD (0–9).

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); legal range 2 to 2^24−1.
- `CLK`  in  1  system clock (50 MHz); all logic on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `BTN_UP`  in  1  raw button, active-high, asynchronous to CLK.
- `BTN_DOWN`  in  1  raw button, active-high, asynchronous to CLK.
- `BTN_CLR`  in  1  raw button, active-high, asynchronous to CLK.
- `units`  out  4  BCD units digit, registered.
- `tens`  out  4  BCD tens digit, registered.
- `hundreds`  out  4  BCD hundreds digit, registered.
- `WRAP`  out  1  one-cycle pulse on a 999→000 or 000→999 transition, registered.

## Operation
- **Per-button input path:** 2-flop synchroniser, then debouncer, then rising-edge detector. The three paths are identical and independent.
- **Debouncer:** 24-bit counter plus `stable` bit.
  - When the synchronised level equals `stable`, the counter clears.
  - When the level differs, the counter increments.
  - When the level still differs with the counter at `DEBOUNCE_CYCLES−1`, `stable` flips and the counter clears on the same edge.
- **Press event:** `stable` = 1 and `stable_d` = 0, where `stable_d` is `stable` delayed by one cycle. The event lasts one cycle per press. Release produces no event.
- **Count update priority (evaluated each cycle):**
  1. CLR event: digits become 000; WRAP = 0.
  2. UP and DOWN events in the same cycle: no change.
  3. UP event: increment with BCD carry. A digit at 9 becomes 0 and carries to the next digit. 999 becomes 000 with WRAP = 1.
  4. DOWN event: decrement with BCD borrow. A digit at 0 becomes 9 and borrows from the next digit. 000 becomes 999 with WRAP = 1.
- **WRAP:** high for exactly the one cycle following the wrapping edge; 0 otherwise.
- **Illegal digit values:** the next-state logic never produces values 10–15.
- **State:** there is no FSM beyond the per-button debounce state (`stable`, counter) and the digit registers.

## Timing
- **Reset values:** `units` = `tens` = `hundreds` = 0, `WRAP` = 0. All synchroniser flops, `stable`, `stable_d` and debounce counters are 0.
- **Latency:** Let N be the first CLK edge at which `sync1` samples the new raw level, and let the raw level be held. Then:
  - `sync2` updates at N+1.
  - `stable` flips at N+`DEBOUNCE_CYCLES`.
  - The event is high during the following cycle.
  - Digits and WRAP update at edge N+`DEBOUNCE_CYCLES`+1.
- **Bounce rejection:** a raw pulse or glitch that leaves the synchronised level mismatched for fewer than `DEBOUNCE_CYCLES` consecutive cycles causes no change.
- **Press rate:** minimum press-to-press interval is 2×`DEBOUNCE_CYCLES` cycles (press plus release). There is no event queue.
- **Reset mid-operation:** all state clears immediately.
  - A button still held after RESET deasserts is treated as a new press: one event after the normal latency.
  - In-flight debounce progress is discarded.
- **Single-cycle update:** digits update atomically. A carry across all three digits, such as 099→100, completes in one edge.

## Configuration
- **`BCD_COUNTER_SATURATE_EN`**
  - **Defined:** the counter saturates. An UP event at 999 and a DOWN event at 000 are ignored (digits unchanged), and WRAP is tied to 0.
  - **Undefined (default):** modulo-1000 wrap with the WRAP pulse, as described in Operation.
  - CLR behaviour is identical in both builds.

## Test plan
Bench uses `DEBOUNCE_CYCLES` = 4 and a 20 ns clock.
- **Reset:** assert RESET mid-count at 437 → outputs 0/0/0 and WRAP = 0 immediately, before the next CLK edge.
- **Single UP press:** from 000, hold UP for 20 cycles → digits 001 exactly at N+5, with no further change while held or on release.
- **Bounce:** UP high for 2 cycles, low for 1, high for 2, low → digits remain 000.
- **Carry and wrap:** preload 099 via presses, then UP → 100. At 999, UP → 000 with WRAP high for exactly 1 cycle. At 000, DOWN → 999 with WRAP pulse. With `BCD_COUNTER_SATURATE_EN`, the same stimuli leave 999 and 000 unchanged with WRAP = 0.
- **Simultaneous events:** UP and DOWN rising on the same edge at 250 → stays 250. CLR together with UP at 250 → 000.
- **Reset while held:** hold DOWN through RESET release from 500 → 000 after reset, then 999 at N+5 after release of RESET (wrap build).
